// File: rtl/trg_defs.sv
// Shared definitions for the trigger controller: FSM encoding, lane layout,
// threshold code and timestamp divider helpers.
package trg_defs;

  localparam int unsigned LANE_W = 16;

  typedef enum logic [1:0] {
    ST_BASELINE  = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIG      = 2'd2,
    ST_WAIT_DOUT = 2'd3
  } trg_state_e;

  // Bit offset of the sample inside a 16-bit lane (samples are left-aligned).
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned adc_w);
    return LANE_W * lane + (LANE_W - adc_w);
  endfunction

  // Threshold as a percentage of full-scale code range.
  function automatic int thresh_code(input int pct, input int adc_w);
    return (pct * (1 << adc_w)) / 100;
  endfunction

  // Clock cycles per timestamp tick.
  function automatic int unsigned timer_div(input real clk_hz, input real tick_hz);
    return int'(clk_hz / tick_hz);
  endfunction

endpackage

// File: rtl/sample_threshold_cmp.sv
// Per-beat lane maximum (combinational, for baseline learning) and registered
// "any lane above threshold" hit flag.
module sample_threshold_cmp
  import trg_defs::*;
#(
  parameter int unsigned TDATA_W = 128,
  parameter int unsigned ADC_W   = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [TDATA_W-1:0]      tdata_i,
  input  logic                    tvalid_i,
  input  logic signed [ADC_W:0]   thresh_i,
  output logic signed [ADC_W-1:0] lane_max_o,
  output logic                    hit_o
);

  localparam int unsigned LANES = TDATA_W / LANE_W;

  logic signed [ADC_W-1:0] lane;
  logic signed [ADC_W-1:0] max_d;
  logic                    any_d;
  logic                    hit_q;
  logic                    unused_lsbs;

  // Scan all lanes for the signed maximum and for any strict threshold excess.
  always_comb begin
    lane        = '0;
    max_d       = {1'b1, {(ADC_W-1){1'b0}}};
    any_d       = 1'b0;
    unused_lsbs = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane = tdata_i[lane_lsb(i, ADC_W) +: ADC_W];
      if (lane > max_d) max_d = lane;
      if ($signed({lane[ADC_W-1], lane}) > thresh_i) any_d = 1'b1;
      unused_lsbs = unused_lsbs ^ (^tdata_i[LANE_W*i +: (LANE_W-ADC_W)]);
    end
  end

  // Register the hit so the FSM sees it one cycle after the beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hit_q <= 1'b0;
    else         hit_q <= tvalid_i & any_d;
  end

  assign lane_max_o = max_d;
  assign hit_o      = hit_q;

endmodule

// File: rtl/trigger_controller.sv
// Ring-buffer trigger sequencer: baseline learning, threshold trigger,
// post-acquisition hold, readout wait, timestamp and event/lost counters.
module trigger_controller
  import trg_defs::*;
#(
  parameter int  THRESHOLD            = 20,
  parameter int  BASELINE_CALC_LEN    = 10,
  parameter int  POST_ACQUI_LEN       = 38,
  parameter int  ACQUI_LEN            = 100,
  parameter real AXIS_ACLK_FREQ       = 500E6,
  parameter real TIMER_RESO_FREQ      = 100E6,
  parameter int  TIME_STAMP_WIDTH     = 16,
  parameter int  ADC_RESOLUTION_WIDTH = 12,
  parameter int  S_AXIS_TDATA_WIDTH   = 128
) (
  input  logic                                   AXIS_ACLK,
  input  logic                                   AXIS_ARESETN,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic                                   S_AXIS_TVALID,
  input  logic                                   TRIG_ENABLE,
  input  logic                                   REBASE,
  input  logic                                   BUF_FULL,
  input  logic                                   O_DOUT_DONE,
  output logic                                   TRIGGERD_FLAG,
  output logic [TIME_STAMP_WIDTH-1:0]            TRIG_TIME,
  output logic                                   TRIG_TIME_VALID,
  output logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic [15:0]                            EVENT_COUNT,
  output logic [15:0]                            LOST_COUNT
);

  localparam int unsigned ADC_W  = ADC_RESOLUTION_WIDTH;
  localparam int unsigned TDIV   = timer_div(AXIS_ACLK_FREQ, TIMER_RESO_FREQ);
  localparam int unsigned DIV_W  = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned CNT_W  = $clog2(BASELINE_CALC_LEN + 1);
  localparam int unsigned HOLD_W = $clog2(POST_ACQUI_LEN + 1);
  localparam int unsigned FLEN_W = $clog2(ACQUI_LEN + 1);

  typedef logic signed [ADC_W:0]   thr_t;
  typedef logic signed [ADC_W-1:0] smp_t;

  localparam thr_t               THR_CODE  = thr_t'(thresh_code(THRESHOLD, ADC_RESOLUTION_WIDTH));
  localparam thr_t               THR_MAX   = thr_t'((1 << (ADC_W-1)) - 1);
  localparam smp_t               SMP_MIN   = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]   BASE_LAST = CNT_W'(BASELINE_CALC_LEN - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(POST_ACQUI_LEN);
  localparam logic [FLEN_W-1:0]  FLEN_MAX  = FLEN_W'(ACQUI_LEN);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TDIV - 1);

  trg_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            base_cnt_q, base_cnt_d;
  smp_t                        run_max_q, run_max_d;
  smp_t                        baseline_q, baseline_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [FLEN_W-1:0]           flen_q, flen_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [TIME_STAMP_WIDTH-1:0] timer_q, timer_d;
  logic [TIME_STAMP_WIDTH-1:0] trig_time_q, trig_time_d;
  logic                        ttv_q, ttv_d;
  logic [15:0]                 evt_q, evt_d;
  logic [15:0]                 lost_q, lost_d;
  logic                        hit_prev_q;
  logic                        lost_inc;
  logic                        hit_r;
  smp_t                        lane_max;
  smp_t                        max_now;
  thr_t                        thresh_sum;
  thr_t                        thresh;

  sample_threshold_cmp #(
    .TDATA_W (S_AXIS_TDATA_WIDTH),
    .ADC_W   (ADC_RESOLUTION_WIDTH)
  ) u_cmp (
    .clk_i      (AXIS_ACLK),
    .rst_ni     (AXIS_ARESETN),
    .tdata_i    (S_AXIS_TDATA),
    .tvalid_i   (S_AXIS_TVALID),
    .thresh_i   (thresh),
    .lane_max_o (lane_max),
    .hit_o      (hit_r)
  );

  // Threshold = baseline + code, clipped to the largest representable sample.
  always_comb begin
    thresh_sum = {baseline_q[ADC_W-1], baseline_q} + THR_CODE;
    thresh     = (thresh_sum > THR_MAX) ? THR_MAX : thresh_sum;
    max_now    = (lane_max > run_max_q) ? lane_max : run_max_q;
  end

  // Free-running timestamp prescaler and counter.
  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      timer_d = timer_q + 1'b1;
    end else begin
      div_d   = div_q + 1'b1;
      timer_d = timer_q;
    end
  end

  // Next-state logic and per-event bookkeeping.
  always_comb begin
    state_d     = state_q;
    base_cnt_d  = base_cnt_q;
    run_max_d   = run_max_q;
    baseline_d  = baseline_q;
    hold_d      = hold_q;
    flen_d      = flen_q;
    trig_time_d = trig_time_q;
    ttv_d       = 1'b0;
    evt_d       = evt_q;
    lost_inc    = 1'b0;
    unique case (state_q)
      ST_BASELINE: begin
        if (REBASE) begin
          base_cnt_d = '0;
          run_max_d  = SMP_MIN;
        end else if (S_AXIS_TVALID) begin
          if (base_cnt_q == BASE_LAST) begin
            baseline_d = max_now;
            base_cnt_d = '0;
            run_max_d  = SMP_MIN;
            state_d    = ST_ARMED;
          end else begin
            run_max_d  = max_now;
            base_cnt_d = base_cnt_q + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (REBASE) begin
          base_cnt_d = '0;
          run_max_d  = SMP_MIN;
          state_d    = ST_BASELINE;
        end else if (hit_r) begin
          if (TRIG_ENABLE && !BUF_FULL) begin
            state_d     = ST_TRIG;
            hold_d      = HOLD_LOAD;
            flen_d      = FLEN_W'(1);
            trig_time_d = timer_q;
            ttv_d       = 1'b1;
            evt_d       = evt_q + 1'b1;
          end else if (TRIG_ENABLE) begin
            lost_inc = 1'b1;
          end
        end
      end
      ST_TRIG: begin
        flen_d = flen_q + 1'b1;
        hold_d = hit_r ? HOLD_LOAD : hold_q - 1'b1;
        if ((!hit_r && hold_q == HOLD_W'(1)) || flen_q == FLEN_MAX) state_d = ST_WAIT_DOUT;
      end
      ST_WAIT_DOUT: begin
        if (O_DOUT_DONE)             state_d  = ST_ARMED;
        else if (hit_r && !hit_prev_q) lost_inc = 1'b1;
      end
      default: state_d = ST_BASELINE;
    endcase
    lost_d = (lost_inc && lost_q != '1) ? lost_q + 1'b1 : lost_q;
  end

  // State and datapath registers.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q     <= ST_BASELINE;
      base_cnt_q  <= '0;
      run_max_q   <= SMP_MIN;
      baseline_q  <= '0;
      hold_q      <= '0;
      flen_q      <= '0;
      div_q       <= '0;
      timer_q     <= '0;
      trig_time_q <= '0;
      ttv_q       <= 1'b0;
      evt_q       <= '0;
      lost_q      <= '0;
      hit_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_cnt_q  <= base_cnt_d;
      run_max_q   <= run_max_d;
      baseline_q  <= baseline_d;
      hold_q      <= hold_d;
      flen_q      <= flen_d;
      div_q       <= div_d;
      timer_q     <= timer_d;
      trig_time_q <= trig_time_d;
      ttv_q       <= ttv_d;
      evt_q       <= evt_d;
      lost_q      <= lost_d;
      hit_prev_q  <= hit_r;
    end
  end

  assign TRIGGERD_FLAG   = (state_q == ST_TRIG);
  assign TRIG_TIME       = trig_time_q;
  assign TRIG_TIME_VALID = ttv_q;
  assign BASELINE        = baseline_q;
  assign EVENT_COUNT     = evt_q;
  assign LOST_COUNT      = lost_q;

endmodule

// File: tb/tb_trigger_controller.sv
// Self-checking bench for trigger_controller: table of single-beat vectors,
// hand-written multi-cycle sequences, and a flag-window scoreboard.
module tb_trigger_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         trig_en = 1'b1;
  logic         rebase = 1'b0;
  logic         buf_full = 1'b0;
  logic         done = 1'b0;
  logic         flag;
  logic [15:0]  ttime;
  logic         ttv;
  logic [11:0]  baseline;
  logic [15:0]  evt_cnt;
  logic [15:0]  lost_cnt;

  always #5 clk = ~clk;

  trigger_controller dut (
    .AXIS_ACLK       (clk),
    .AXIS_ARESETN    (rst_n),
    .S_AXIS_TDATA    (tdata),
    .S_AXIS_TVALID   (tvalid),
    .TRIG_ENABLE     (trig_en),
    .REBASE          (rebase),
    .BUF_FULL        (buf_full),
    .O_DOUT_DONE     (done),
    .TRIGGERD_FLAG   (flag),
    .TRIG_TIME       (ttime),
    .TRIG_TIME_VALID (ttv),
    .BASELINE        (baseline),
    .EVENT_COUNT     (evt_cnt),
    .LOST_COUNT      (lost_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int exp_lost = 0;
  int exp_evt  = 0;

  typedef struct { int start; int len; } flag_exp_t;
  flag_exp_t sb[$];

  typedef struct {
    int   val;
    int   lane;
    logic en;
    logic full;
    int   d_lost;
    int   d_evt;
    int   flen;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input int ev, input int od);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[16*i+4 +: 12] = 12'((i % 2 == 0) ? ev : od);
    return d;
  endfunction

  function automatic logic [127:0] one_lane(input int bg, input int lane, input int v);
    logic [127:0] d;
    d = mk_beat(bg, bg);
    d[16*lane+4 +: 12] = 12'(v);
    return d;
  endfunction

  // Posedges since reset release; the DUT timestamp equals cyc/5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Flag-window monitor: measures each high run and compares it with the scoreboard.
  logic flag_prev = 1'b0;
  int   run_start = 0;
  int   run_len = 0;
  flag_exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      flag_prev = 1'b0;
      run_len   = 0;
    end else begin
      if (flag && !flag_prev) begin
        check("trig_time_valid_at_rise", ttv, 1);
        check("trig_time", ttime, 16'((cyc - 1) / 5));
        run_start = cyc;
        run_len   = 0;
      end else begin
        check("trig_time_valid_idle", ttv, 0);
      end
      if (flag) run_len++;
      if (!flag && flag_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flag start=%0d len=%0d required=no_flag", run_start, run_len);
        end else begin
          e = sb.pop_front();
          check("flag_start", run_start, e.start);
          check("flag_len", run_len, e.len);
        end
      end
      flag_prev = flag;
    end
  end

  task automatic beat(input logic [127:0] d);
    @(negedge clk);
    tdata  = d;
    tvalid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tdata  = '0;
      done   = 1'b0;
      rebase = 1'b0;
    end
  endtask

  task automatic dout_done();
    @(negedge clk);
    tvalid = 1'b0;
    done   = 1'b1;
    idle(1);
  endtask

  task automatic pulse(input int nhit, input int ntail, input logic [127:0] hitd, input int exp_len);
    for (int i = 0; i < nhit; i++) begin
      beat(hitd);
      if (i == 0 && exp_len > 0) sb.push_back(flag_exp_t'{cyc + 2, exp_len});
    end
    for (int i = 0; i < ntail; i++) beat(mk_beat(-1629, -1629));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flag"}, flag, 0);
    check({tag, "_trig_time"}, ttime, 0);
    check({tag, "_trig_time_valid"}, ttv, 0);
    check({tag, "_baseline"}, $signed(baseline), 0);
    check({tag, "_event_count"}, evt_cnt, 0);
    check({tag, "_lost_count"}, lost_cnt, 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_event_count"}, evt_cnt, exp_evt);
    check({tag, "_lost_count"}, lost_cnt, exp_lost);
    check({tag, "_scoreboard_empty"}, sb.size(), 0);
  endtask

  initial begin
    // Threshold after first baseline is -2036 + 819 = -1217 (strict compare).
    vt[0] = '{-1217, 3, 1'b1, 1'b1, 0, 0, 0};
    vt[1] = '{-1216, 3, 1'b1, 1'b1, 1, 0, 0};
    vt[2] = '{ 1238, 7, 1'b0, 1'b0, 0, 0, 0};
    vt[3] = '{ 2047, 0, 1'b1, 1'b1, 1, 0, 0};
    vt[4] = '{-1216, 5, 1'b1, 1'b0, 0, 1, 38};

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Baseline learning with an invalid high beat in the middle.
    for (int i = 0; i < 5; i++) beat(mk_beat(-2038, -2036));
    @(negedge clk);
    tvalid = 1'b0;
    tdata  = mk_beat(2000, 2000);
    for (int i = 0; i < 4; i++) beat(mk_beat(-2038, -2036));
    idle(1);
    check("baseline_after_9", $signed(baseline), 0);
    beat(mk_beat(-2038, -2036));
    idle(1);
    check("baseline_after_10", $signed(baseline), -2036);

    // Single-beat vectors: threshold boundary, BUF_FULL, TRIG_ENABLE.
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      trig_en  = vt[r].en;
      buf_full = vt[r].full;
      tdata    = one_lane(-2038, vt[r].lane, vt[r].val);
      tvalid   = 1'b1;
      if (vt[r].d_evt != 0) sb.push_back(flag_exp_t'{cyc + 2, vt[r].flen});
      exp_lost += vt[r].d_lost;
      exp_evt  += vt[r].d_evt;
      idle(50);
      check_counts($sformatf("vec%0d", r));
      trig_en  = 1'b1;
      buf_full = 1'b0;
      if (vt[r].d_evt != 0) dout_done();
    end

    // Ten-beat pulse: 47-cycle flag window.
    pulse(10, 20, mk_beat(1238, 1238), 47);
    exp_evt++;
    idle(30);
    check_counts("pulse1");

    // Second pulse while waiting for readout: lost, no flag.
    for (int i = 0; i < 100; i++) beat(mk_beat(-2038, -2036));
    pulse(10, 20, mk_beat(1238, 1238), 0);
    exp_lost++;
    idle(10);
    check_counts("pulse2_lost");

    dout_done();
    pulse(10, 20, mk_beat(1238, 1238), 47);
    exp_evt++;
    idle(30);
    check_counts("pulse3");
    dout_done();

    // Long hit: flag capped at 100 cycles, then stays low in readout wait.
    pulse(200, 20, mk_beat(1238, 1238), 100);
    exp_evt++;
    idle(10);
    check_counts("cap");
    dout_done();

    // Rebase from ARMED, then check the moved threshold (-1500 + 819 = -681).
    @(negedge clk);
    tvalid = 1'b0;
    rebase = 1'b1;
    idle(1);
    for (int i = 0; i < 10; i++) beat(mk_beat(-1500, -1600));
    idle(1);
    check("baseline_rebase", $signed(baseline), -1500);
    buf_full = 1'b1;
    beat(one_lane(-1600, 2, -681));
    idle(10);
    check_counts("rebase_at_thresh");
    beat(one_lane(-1600, 2, -680));
    exp_lost++;
    idle(10);
    check_counts("rebase_above_thresh");
    buf_full = 1'b0;

    // Asynchronous reset during flag cycle 5.
    for (int i = 0; i < 7; i++) begin
      beat(mk_beat(1238, 1238));
      if (i == 2) check("flag_before_reset", flag, 1);
    end
    #1 rst_n = 1'b0;
    #1 check_reset("midtrig_reset");
    sb.delete();
    exp_evt  = 0;
    exp_lost = 0;
    idle(3);
    rst_n = 1'b1;

    // Re-learn baseline (-1000, threshold -181) and trigger once more.
    for (int i = 0; i < 10; i++) beat(mk_beat(-1000, -1100));
    idle(1);
    check("baseline_after_reset", $signed(baseline), -1000);
    check_counts("after_reset");
    pulse(10, 20, mk_beat(1238, 1238), 47);
    exp_evt++;
    idle(30);
    check_counts("post_reset_pulse");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
